// File: rtl/uart_clock_cmd_pkg.sv
// ASCII constants, parser states and reply record for the clock command block.
// Shared by uart_clock_cmd and cmd_reply_seq.
package clk_cmd_pkg;

  localparam logic [7:0] A_CR = 8'h0D;
  localparam logic [7:0] A_LF = 8'h0A;
  localparam logic [7:0] A_0  = 8'h30;
  localparam logic [7:0] A_9  = 8'h39;
  localparam logic [7:0] A_SU = 8'h53;
  localparam logic [7:0] A_SL = 8'h73;
  localparam logic [7:0] A_RU = 8'h52;
  localparam logic [7:0] A_RL = 8'h72;
  localparam logic [7:0] A_QU = 8'h51;
  localparam logic [7:0] A_QL = 8'h71;
  localparam logic [7:0] A_K  = 8'h4B;
  localparam logic [7:0] A_QM = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    S_TENS,
    S_ONES,
    S_CR,
    R_CR,
    Q_CR,
    DISCARD,
    REPLY
  } state_t;

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [1:0] len;
  } reply_t;

  function automatic logic [7:0] to_ascii(
    input logic [3:0] d
  );
    return A_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/uart_clock_cmd_if.sv
// Byte streams between the UART and the command block.
// master = UART side (rx bytes, tx_ready); slave = command block.
interface uart_clock_cmd_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/cmd_reply_seq.sv
// Reply sender: loads up to 3 bytes on start, streams them over valid/ready.
// Ports: clk, resett (sync, low), start, rep, tx_ready -> tx_data, tx_valid, done.
module cmd_reply_seq
  import clk_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       resett,
  input  logic       start,
  input  reply_t     rep,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       done
);

  logic [2:0][7:0] buf_q;
  logic [1:0]      len_q;
  logic [1:0]      idx;
  logic [1:0]      nxt;
  logic            hs;
  logic            last;

  assign hs   = tx_valid && tx_ready;
  assign nxt  = idx + 2'd1;
  assign last = (idx == len_q - 2'd1);
  // Combinational so the parser leaves REPLY on the final handshake edge.
  assign done = hs && last;

  always_ff @(posedge clk) begin
    if (!resett) begin
      buf_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (start) begin
      buf_q    <= {rep.b2, rep.b1, rep.b0};
      len_q    <= rep.len;
      idx      <= '0;
      tx_data  <= rep.b0;
      tx_valid <= 1'b1;
    end else if (hs) begin
      if (last) begin
        tx_valid <= 1'b0;
      end else begin
        idx     <= nxt;
        tx_data <= buf_q[nxt];
      end
    end
  end

endmodule

// File: rtl/uart_clock_cmd.sv
// ASCII set/reset/query command parser driving num_split, with TX reply.
// Ports: clk, resett, bus (rx/tx), cur_l/m in; reconfig_l/m/en, digit_rst, busy out.
module uart_clock_cmd
  import clk_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TENS_MAX    = 5
) (
  input  logic             clk,
  input  logic             resett,
  uart_clock_cmd_if.slave  bus,
  input  logic [3:0]       cur_l,
  input  logic [3:0]       cur_m,
  output logic [3:0]       reconfig_l,
  output logic [3:0]       reconfig_m,
  output logic             reconfig_en,
  output logic             digit_rst,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] TENS_TOP = A_0 + 8'(TENS_MAX);

  localparam reply_t OK_R = '{
    b0: A_K, b1: A_CR, b2: 8'h00, len: 2'd2
  };
  localparam reply_t ERR_R = '{
    b0: A_QM, b1: A_CR, b2: 8'h00, len: 2'd2
  };

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    d1;
  logic [3:0]    d0;
  logic          start;
  reply_t        rep;
  logic          done;

  logic [7:0] rx;
  logic [3:0] dig;
  logic       is_cr;
  logic       is_lf;
  logic       is_s;
  logic       is_r;
  logic       is_q;
  logic       is_dig;
  logic       is_tens;
  logic       parsing;

  assign rx      = bus.rx_data;
  assign dig     = 4'(rx - A_0);
  assign is_cr   = (rx == A_CR);
  assign is_lf   = (rx == A_LF);
  assign is_s    = (rx == A_SU) || (rx == A_SL);
  assign is_r    = (rx == A_RU) || (rx == A_RL);
  assign is_q    = (rx == A_QU) || (rx == A_QL);
  assign is_dig  = (rx >= A_0) && (rx <= A_9);
  assign is_tens = (rx >= A_0) && (rx <= TENS_TOP);
  assign parsing = (state != IDLE) && (state != REPLY);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resett) begin
      state       <= IDLE;
      cnt         <= '0;
      d1          <= '0;
      d0          <= '0;
      reconfig_l  <= '0;
      reconfig_m  <= '0;
      reconfig_en <= 1'b0;
      digit_rst   <= 1'b0;
      start       <= 1'b0;
      rep         <= '0;
    end else begin
      reconfig_en <= 1'b0;
      digit_rst   <= 1'b0;
      start       <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            unique case (1'b1)
              is_s:           state <= S_TENS;
              is_r:           state <= R_CR;
              is_q:           state <= Q_CR;
              is_cr || is_lf: state <= IDLE;
              default:        state <= DISCARD;
            endcase
          end
        end
        S_TENS: begin
          if (bus.rx_valid) begin
            if (is_tens) begin
              d1    <= dig;
              state <= S_ONES;
            end else if (is_cr) begin
              rep   <= ERR_R;
              start <= 1'b1;
              state <= REPLY;
            end else begin
              state <= DISCARD;
            end
          end
        end
        S_ONES: begin
          if (bus.rx_valid) begin
            if (is_dig) begin
              d0    <= dig;
              state <= S_CR;
            end else if (is_cr) begin
              rep   <= ERR_R;
              start <= 1'b1;
              state <= REPLY;
            end else begin
              state <= DISCARD;
            end
          end
        end
        S_CR: begin
          if (bus.rx_valid) begin
            if (is_cr) begin
              reconfig_m  <= d1;
              reconfig_l  <= d0;
              reconfig_en <= 1'b1;
              rep         <= OK_R;
              start       <= 1'b1;
              state       <= REPLY;
            end else begin
              state <= DISCARD;
            end
          end
        end
        R_CR: begin
          if (bus.rx_valid) begin
            if (is_cr) begin
              digit_rst <= 1'b1;
              rep       <= OK_R;
              start     <= 1'b1;
              state     <= REPLY;
            end else begin
              state <= DISCARD;
            end
          end
        end
        Q_CR: begin
          if (bus.rx_valid) begin
            if (is_cr) begin
              // rep doubles as the snapshot of the live digits.
              rep <= '{
                b0: to_ascii(cur_m),
                b1: to_ascii(cur_l),
                b2: A_CR,
                len: 2'd3
              };
              start <= 1'b1;
              state <= REPLY;
            end else begin
              state <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (bus.rx_valid && is_cr) begin
            rep   <= ERR_R;
            start <= 1'b1;
            state <= REPLY;
          end
        end
        REPLY: begin
          if (done) begin
            state <= IDLE;
          end
        end
      endcase

      // Expiry only acts on idle cycles, so an arriving byte always wins.
      if (parsing) begin
        if (bus.rx_valid) begin
          cnt <= '0;
        end else if (cnt == TO_LAST) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  cmd_reply_seq u_reply (
    .clk      (clk),
    .resett   (resett),
    .start    (start),
    .rep      (rep),
    .tx_ready (bus.tx_ready),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .done     (done)
  );

endmodule

// File: tb/tb_uart_clock_cmd.sv
// Bench for uart_clock_cmd: command table plus directed timing sequences.
// Expected tx bytes are queued on stimulus and popped at each handshake.
module tb_uart_clock_cmd;
  import clk_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       resett = 1'b0;
  logic [3:0] cur_l = '0;
  logic [3:0] cur_m = '0;
  logic [3:0] reconfig_l;
  logic [3:0] reconfig_m;
  logic       reconfig_en;
  logic       digit_rst;
  logic       busy;

  uart_clock_cmd_if bus();

  uart_clock_cmd #(
    .TIMEOUT_CYC (16),
    .TENS_MAX    (5)
  ) dut (
    .clk         (clk),
    .resett      (resett),
    .bus         (bus),
    .cur_l       (cur_l),
    .cur_m       (cur_m),
    .reconfig_l  (reconfig_l),
    .reconfig_m  (reconfig_m),
    .reconfig_en (reconfig_en),
    .digit_rst   (digit_rst),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string cmd;
    int    cm;
    int    cl;
    int    n_en;
    int    n_rst;
    int    em;
    int    el;
    string reply;
    int    mode;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  byte        expq[$];
  int         en_cnt = 0;
  int         rst_cnt = 0;
  int         rdy_mode = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  int         exp_m = 0;
  int         exp_l = 0;
  vec_t       vt[13];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic byte xlat(byte c);
    if (c == "." ) return byte'(A_CR);
    if (c == "|" ) return byte'(A_LF);
    return c;
  endfunction

  function automatic vec_t mk(string c, int m, int l, int ne,
                              int nr, int em, int el,
                              string rp, int md);
    vec_t v;
    v.cmd = c; v.cm = m; v.cl = l;
    v.n_en = ne; v.n_rst = nr; v.em = em; v.el = el;
    v.reply = rp; v.mode = md;
    return v;
  endfunction

  task automatic send(byte b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(xlat(s[i]));
  endtask

  task automatic push_str(string s);
    for (int i = 0; i < s.len(); i++) expq.push_back(xlat(s[i]));
  endtask

  task automatic wait_done(string nm);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_left"}, expq.size(), 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  // tx_ready driver: 0 always ready, 1 random, 2 toggle, 3 stalled,
  // anything else leaves it to the main sequence.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = 1'($urandom_range(0, 1));
        2: bus.tx_ready = ~bus.tx_ready;
        3: bus.tx_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Monitor: strobe counting, hold stability and scoreboard pops.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (resett) begin
        if (reconfig_en === 1'b1) en_cnt++;
        if (digit_rst === 1'b1) rst_cnt++;
        if (prev_hold) begin
          chk("tx_hold_valid", bus.tx_valid, 1);
          chk("tx_hold_data", bus.tx_data, prev_data);
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got %0h expected none",
                     bus.tx_data);
          end else begin
            chk("tx_byte", bus.tx_data, expq.pop_front());
          end
        end
      end
      prev_hold = resett && bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk("S69.",  0, 0, 0, 0, 0, 0, "?.", 0);
    vt[1]  = mk("s50.",  0, 0, 1, 0, 5, 0, "K.", 1);
    vt[2]  = mk("S5A.",  0, 0, 0, 0, 0, 0, "?.", 0);
    vt[3]  = mk(".|S.",  0, 0, 0, 0, 0, 0, "?.", 1);
    vt[4]  = mk("S4.",   0, 0, 0, 0, 0, 0, "?.", 0);
    vt[5]  = mk("r.|",   0, 0, 0, 1, 0, 0, "K.", 1);
    vt[6]  = mk("Q.",    2, 9, 0, 0, 0, 0, "29.", 0);
    vt[7]  = mk("X.",    0, 0, 0, 0, 0, 0, "?.", 1);
    vt[8]  = mk("S47x.", 0, 0, 0, 0, 0, 0, "?.", 0);
    vt[9]  = mk("S09.",  0, 0, 1, 0, 0, 9, "K.", 1);
    vt[10] = mk("QQ.",   0, 0, 0, 0, 0, 0, "?.", 0);
    vt[11] = mk("q.",    3, 8, 0, 0, 0, 0, "38.", 2);
    vt[12] = mk("R.|",   0, 0, 0, 1, 0, 0, "K.", 1);

    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", reconfig_en, 0);
    chk("rst_drst", digit_rst, 0);
    chk("rst_l", reconfig_l, 0);
    chk("rst_m", reconfig_m, 0);
    resett = 1'b1;

    // S47: strobe first, tx_valid one cycle later.
    en_cnt = 0;
    push_str("K.");
    send_str("S47.");
    chk("s47_en_now", reconfig_en, 1);
    chk("s47_txv_now", bus.tx_valid, 0);
    @(posedge clk);
    #1;
    chk("s47_en_next", reconfig_en, 0);
    chk("s47_txv_next", bus.tx_valid, 1);
    chk("s47_tx_k", bus.tx_data, A_K);
    wait_done("s47");
    chk("s47_en_cnt", en_cnt, 1);
    chk("s47_m", reconfig_m, 4);
    chk("s47_l", reconfig_l, 7);
    exp_m = 4;
    exp_l = 7;

    for (int i = 0; i < 13; i++) begin
      rdy_mode = vt[i].mode;
      cur_m = 4'(vt[i].cm);
      cur_l = 4'(vt[i].cl);
      en_cnt = 0;
      rst_cnt = 0;
      push_str(vt[i].reply);
      send_str(vt[i].cmd);
      wait_done($sformatf("v%0d", i));
      if (vt[i].n_en != 0) begin
        exp_m = vt[i].em;
        exp_l = vt[i].el;
      end
      chk($sformatf("v%0d_en", i), en_cnt, vt[i].n_en);
      chk($sformatf("v%0d_rst", i), rst_cnt, vt[i].n_rst);
      chk($sformatf("v%0d_m", i), reconfig_m, exp_m);
      chk($sformatf("v%0d_l", i), reconfig_l, exp_l);
    end
    rdy_mode = 0;

    // Partial command expires after 16 idle cycles.
    en_cnt = 0;
    rst_cnt = 0;
    cur_m = 4'd1;
    cur_l = 4'd2;
    push_str("12.");
    send_str("S4");
    repeat (16) @(negedge clk);
    send_str("Q.");
    wait_done("to");
    chk("to_en", en_cnt, 0);
    chk("to_rst", rst_cnt, 0);

    // A byte on the last counted cycle beats expiry.
    en_cnt = 0;
    push_str("K.");
    send_str("S4");
    repeat (15) @(negedge clk);
    send_str("7.");
    wait_done("win");
    chk("win_en", en_cnt, 1);
    chk("win_m", reconfig_m, 4);
    chk("win_l", reconfig_l, 7);

    // Reset while the second query byte is waiting.
    rdy_mode = 9;
    bus.tx_ready = 1'b0;
    cur_m = 4'd6;
    cur_l = 4'd1;
    expq.push_back(8'h36);
    send_str("Q.");
    for (int n = 0; n < 50 && bus.tx_valid !== 1'b1; n++)
      @(negedge clk);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    chk("rr_b2_valid", bus.tx_valid, 1);
    chk("rr_b2_data", bus.tx_data, 8'h31);
    resett = 1'b0;
    @(posedge clk);
    #1;
    chk("rr_txv", bus.tx_valid, 0);
    chk("rr_busy", busy, 0);
    @(negedge clk);
    resett = 1'b1;
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    chk("rr_left", expq.size(), 0);
    chk("rr_txv_after", bus.tx_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
